// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a bank of WIDTH JK flip-flops towards a requested
// target word. It strobes J/K for one cycle, waits for the feedback to settle,
// verifies it against the target, and retries a bounded number of times before
// flagging an error.
//
// Optional build macro: JK_TOGGLE_EXC_EN
//   defined   - changing bits are driven with the toggle code (J=1, K=1)
//   undefined - changing bits use set (J=1, K=0) / reset (J=0, K=1) codes
module jk_excitation_driver #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned SC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  tgt_q;
  logic [RC_W-1:0]   rc_q;
  logic [SC_W-1:0]   sc_q;
  logic [WIDTH-1:0]  jk_j_q;
  logic [WIDTH-1:0]  jk_k_q;
  logic              jk_en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              req_ready_q;

  logic [WIDTH-1:0]  jk_j_d;
  logic [WIDTH-1:0]  jk_k_d;
  logic              retry_ok;
  logic              match;

  // Per-bit excitation from the live feedback towards the latched target.
  always_comb begin
    jk_j_d = '0;
    jk_k_d = '0;
`ifdef JK_TOGGLE_EXC_EN
    jk_j_d = q_fb ^ tgt_q;
    jk_k_d = q_fb ^ tgt_q;
`else
    jk_j_d = ~q_fb & tgt_q;
    jk_k_d = q_fb & ~tgt_q;
`endif
  end

  // Verification and retry budget decisions used in CHECK.
  always_comb begin
    match    = (q_fb == tgt_q);
    retry_ok = (32'(rc_q) < MAX_RETRY);
  end

  // Controller: request accept, strobe, settle wait, verify/retry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tgt_q       <= '0;
      rc_q        <= '0;
      sc_q        <= '0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      jk_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      // Strobe, excitation and result pulses are single-cycle by default.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      jk_en_q <= 1'b0;
      jk_j_q  <= '0;
      jk_k_q  <= '0;

      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            tgt_q       <= req_target;
            rc_q        <= '0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          jk_j_q  <= jk_j_d;
          jk_k_q  <= jk_k_d;
          jk_en_q <= 1'b1;
          sc_q    <= SC_W'(SETTLE_CYCLES);
          state_q <= S_SETTLE;
        end

        S_SETTLE: begin
          sc_q <= sc_q - SC_W'(1);
          // A count of one here means this edge takes it to zero.
          if (sc_q <= SC_W'(1)) begin
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (match) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (retry_ok) begin
            rc_q    <= rc_q + RC_W'(1);
            state_q <= S_DRIVE;
          end else begin
            err_q       <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign jk_en     = jk_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver with a behavioural JK bank model.
module tb_jk_excitation_driver;

  localparam int unsigned W = 4;

  localparam int K_BAD  = 0;
  localparam int K_STB  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic         clk        = 1'b0;
  logic         reset      = 1'b1;
  logic         req_valid  = 1'b0;
  logic [W-1:0] req_target = '0;
  logic         req_ready;
  logic [W-1:0] q_fb;
  logic [W-1:0] jk_j;
  logic [W-1:0] jk_k;
  logic         jk_en;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  jk_excitation_driver #(
    .WIDTH        (W),
    .SETTLE_CYCLES(2),
    .MAX_RETRY    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_target(req_target),
    .q_fb      (q_fb),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .jk_en     (jk_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // JK bank model: mode 0 normal, 1 ignores first strobe, 2 stuck.
  logic [W-1:0] bank_q    = '0;
  logic         load      = 1'b0;
  logic [W-1:0] load_val  = '0;
  int           bank_mode = 0;
  int           strobes   = 0;

  assign q_fb = bank_q;

  always @(posedge clk) begin
    if (load) begin
      bank_q  <= load_val;
      strobes <= 0;
    end else if (jk_en) begin
      strobes <= strobes + 1;
      if (bank_mode == 0 || (bank_mode == 1 && strobes >= 1))
        bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    int           cyc;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         rdy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every strobe/done/err is popped against the scoreboard.
  always @(negedge clk) begin
    int   act;
    exp_t e;
    if (!reset && (jk_en || done || err)) begin
      act = (int'(jk_en) + int'(done) + int'(err) > 1) ? K_BAD :
            jk_en ? K_STB : (done ? K_DONE : K_ERR);
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got kind=%0d at cycle %0d, expected no event", act, cyc);
      end else begin
        e = sb.pop_front();
        if (act != e.kind || cyc != e.cyc || jk_j !== e.j || jk_k !== e.k ||
            busy !== e.busy || req_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL event: got kind=%0d cyc=%0d j=%b k=%b busy=%b rdy=%b, expected kind=%0d cyc=%0d j=%b k=%b busy=%b rdy=%b",
                   act, cyc, jk_j, jk_k, busy, req_ready, e.kind, e.cyc, e.j, e.k, e.busy, e.rdy);
        end
      end
    end
  end

  function automatic void expect_ev(int kind, int c, logic [W-1:0] j, logic [W-1:0] k);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.j    = j;
    e.k    = k;
    e.busy = (kind == K_STB);
    e.rdy  = (kind != K_STB);
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v, input int mode);
    @(negedge clk);
    load      = 1'b1;
    load_val  = v;
    bank_mode = mode;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Presents a request and returns the cycle number of its accept edge.
  task automatic issue(input logic [W-1:0] t, output int acc);
    logic rdy;
    bit   got;
    acc = -1;
    got = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = t;
    for (int i = 0; i < 200; i++) begin
      rdy = req_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    n_tests++;
    if (sb.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending events busy=%b, expected 0 pending busy=0", name, sb.size(), busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] init, input int mode,
                        input logic [W-1:0] tgt, input int nstb,
                        input logic [W-1:0] ej, input logic [W-1:0] ek,
                        input int fin, input logic [W-1:0] bank_exp);
    int acc;
    load_bank(init, mode);
    issue(tgt, acc);
    for (int s = 0; s < nstb; s++) expect_ev(K_STB, acc + 1 + 4 * s, ej, ek);
    expect_ev(fin, acc + 4 * nstb, '0, '0);
    drain(name);
    check({name, "_bank"}, 32'(bank_q), 32'(bank_exp));
  endtask

  initial begin
    int acc1;
    int acc2;

    // Reset state, asynchronous, before any clock edge.
    #1;
    check("reset_outputs", 32'({req_ready, jk_en, busy, done, err, jk_j, jk_k}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'd1);

`ifdef JK_TOGGLE_EXC_EN
    run_op("basic", 4'b0011, 0, 4'b0101, 1, 4'b0110, 4'b0110, K_DONE, 4'b0101);
    run_op("hold",  4'b1010, 0, 4'b1010, 1, 4'b0000, 4'b0000, K_DONE, 4'b1010);
    run_op("retry", 4'b0000, 1, 4'b0110, 2, 4'b0110, 4'b0110, K_DONE, 4'b0110);
    run_op("exhaust", 4'b0000, 2, 4'b1111, 4, 4'b1111, 4'b1111, K_ERR, 4'b0000);
`else
    run_op("basic", 4'b0011, 0, 4'b0101, 1, 4'b0100, 4'b0010, K_DONE, 4'b0101);
    run_op("hold",  4'b1010, 0, 4'b1010, 1, 4'b0000, 4'b0000, K_DONE, 4'b1010);
    run_op("retry", 4'b0000, 1, 4'b0110, 2, 4'b0110, 4'b0000, K_DONE, 4'b0110);
    run_op("exhaust", 4'b0000, 2, 4'b1111, 4, 4'b1111, 4'b0000, K_ERR, 4'b0000);
`endif

    // Handshake: valid held with a new target while busy.
    load_bank(4'b0000, 0);
    issue(4'b0001, acc1);
`ifdef JK_TOGGLE_EXC_EN
    expect_ev(K_STB, acc1 + 1, 4'b0001, 4'b0001);
`else
    expect_ev(K_STB, acc1 + 1, 4'b0001, 4'b0000);
`endif
    expect_ev(K_DONE, acc1 + 4, '0, '0);
    req_valid  = 1'b1;
    req_target = 4'b1000;
    issue(4'b1000, acc2);
    check("hs_accept_cycle", 32'(acc2), 32'(acc1 + 5));
`ifdef JK_TOGGLE_EXC_EN
    expect_ev(K_STB, acc2 + 1, 4'b1001, 4'b1001);
`else
    expect_ev(K_STB, acc2 + 1, 4'b1000, 4'b0001);
`endif
    expect_ev(K_DONE, acc2 + 4, '0, '0);
    drain("handshake");
    check("handshake_bank", 32'(bank_q), 32'(4'b1000));

    // Reset while settling, right after the strobe was raised.
    load_bank(4'b0011, 0);
    issue(4'b0101, acc1);
`ifdef JK_TOGGLE_EXC_EN
    expect_ev(K_STB, acc1 + 1, 4'b0110, 4'b0110);
`else
    expect_ev(K_STB, acc1 + 1, 4'b0100, 4'b0010);
`endif
    @(negedge clk);
    check("pre_reset_strobe", 32'(jk_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midop_reset_outputs", 32'({req_ready, jk_en, busy, done, err, jk_j, jk_k}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("midop_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("midop_ready_after_release", 32'({req_ready, busy}), 32'b10);
    repeat (12) @(negedge clk);
    check("midop_no_pending", 32'(sb.size()), 32'd0);
    check("midop_idle", 32'({req_ready, busy}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Driver-side controller for a bank of WIDTH JK flip-flops.
- Accepts a target state word over a valid/ready handshake.
- Computes per-bit J/K excitation from the bank's current Q feedback and strobes the bank for one cycle.
- Waits for feedback to settle, then verifies Q == target, retrying up to MAX_RETRY times before flagging an error.

Parameters:
- WIDTH, 4, number of JK flip-flops driven (1..32).
- SETTLE_CYCLES, 2, cycles waited after a strobe before comparing feedback (1..15).
- MAX_RETRY, 3, additional drive attempts after a failed compare (0..7).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  target request valid.
- req_ready  output  1  block can accept a request.
- req_target  input  WIDTH  desired next state of the JK bank.
- q_fb  input  WIDTH  Q outputs fed back from the JK bank.
- jk_j  output  WIDTH  J inputs to the bank.
- jk_k  output  WIDTH  K inputs to the bank.
- jk_en  output  1  one-cycle strobe; the bank updates on the clk edge where jk_en=1.
- busy  output  1  high from request acceptance until done/err.
- done  output  1  one-cycle pulse: bank verified equal to target.
- err  output  1  one-cycle pulse: retries exhausted and bank still mismatched.

Behaviour:

Reset:
- Clock is clk; reset is asynchronous, active-high.
- While reset=1: state=IDLE; jk_j=0, jk_k=0, jk_en=0, busy=0, done=0, err=0, req_ready=0.
- req_ready rises on the first posedge after reset deasserts.
- Reset mid-operation aborts immediately. No done/err is emitted, and the pending target is discarded.

Outputs:
- All outputs are registered.

States:
- IDLE: req_ready=1. On an edge with req_valid&&req_ready:
  - latch req_target into tgt;
  - retry count rc=0;
  - busy<=1, req_ready<=0;
  - go to DRIVE.
- DRIVE (one cycle): on the edge, for each bit i, jk_j/jk_k are computed from q_fb[i] and tgt[i]. Excitation rules:
  - q=t: J=0, K=0 (hold).
  - 0->1: J=1, K=0.
  - 1->0: J=0, K=1.
  - Also on that edge: jk_en<=1, settle counter sc<=SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - First edge: jk_en<=0, jk_j<=0, jk_k<=0.
  - sc decrements each edge; when sc reaches 0, go to CHECK.
- CHECK (one cycle), comparing q_fb against tgt:
  - If q_fb==tgt: done<=1, busy<=0; go to IDLE (req_ready<=1).
  - Else if rc<MAX_RETRY: rc<=rc+1; go to DRIVE. J/K are recomputed from the current q_fb.
  - Else: err<=1, busy<=0; go to IDLE.

Timing and handshake rules:
- done/err are single-cycle pulses and are mutually exclusive.
- req_valid is ignored outside IDLE. Requests are never queued.
- req_target must be stable only on the accept edge.
- A target equal to the current q_fb still performs one strobe with J=K=0, then returns done.
- Latency, accept edge to done: 2+SETTLE_CYCLES cycles, no retries. Each retry adds 2+SETTLE_CYCLES.
- Back-to-back operation: a new request can be accepted on the edge after the done/err pulse. The pulse and req_ready=1 are visible in the same cycle.
- Width rules:
  - rc is ceil(log2(MAX_RETRY+1)) bits, minimum 1.
  - sc is 4 bits.
  - The comparison is full WIDTH. X/Z on q_fb is treated as a mismatch by the bench only.

Optional Feature:
- Macro: JK_TOGGLE_EXC_EN.
- Defined: changing bits use the toggle code J=1, K=1 for both 0->1 and 1->0. Unchanged bits stay J=0, K=0.
- Not defined: set/reset codes exactly as listed under Behaviour.
- Handshake, timing and verification are identical in both builds.

Test Plan:
1. Reset: assert reset mid-SETTLE with jk_en previously 1. Required: all outputs 0 immediately, without waiting for a clock; req_ready=1 one edge after release; no done.
2. Basic drive (WIDTH=4, SETTLE_CYCLES=2): q_fb=4'b0011, target 4'b0101, model bank correct. Required: one strobe with jk_j=4'b0100, jk_k=4'b0010 (toggle build: jk_j=jk_k=4'b0110); done pulse 4 cycles after accept; err=0.
3. Hold case: q_fb=4'b1010, target 4'b1010. Required: strobe with jk_j=jk_k=0; done after 4 cycles.
4. Retry success: model bank ignores the first strobe, applies the second. Required: two jk_en pulses 4 cycles apart; done after 8 cycles; err=0.
5. Retry exhaustion (MAX_RETRY=3): model bank stuck at 4'b0000, target 4'b1111. Required: four jk_en pulses; err pulse after 16 cycles; no done.
6. Handshake: hold req_valid=1 with a new target during busy. Required: no accept until IDLE; the second target is accepted on the edge after the first done; no lost or duplicated operation.
